incr_stream_checker: RTL



---
 rtl/incr_stream_checker.sv | 80 ++++++++
 1 files changed

// File: rtl/incr_stream_checker.sv
// incr_stream_checker: locks onto a mod-2^WIDTH incrementing stream, flags/counts mismatches, optional latency (LATENCY_MEAS_EN)
module incr_stream_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] ref_d,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] latency
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(LOSS_COUNT + 1);
  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;
  state_t state, state_nx;
  logic [MW-1:0] match_cnt, match_nx;
  logic [SW-1:0] miss_cnt, miss_nx;
  logic [WIDTH-1:0] expected_nx;
  logic [ERR_W-1:0] err_nx;
  logic pulse_nx, hit, in_locked, lock_hit, loss_hit;
  assign hit       = d == expected;
  assign in_locked = state == LOCKED;
  assign lock_hit  = hit && int'(match_cnt) + 1 == LOCK_COUNT;
  assign loss_hit  = !hit && int'(miss_cnt) + 1 == LOSS_COUNT;
  // state and registered outputs; reset wins over ce
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= SEARCH;
      match_cnt <= '0;
      miss_cnt  <= '0;
      expected  <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nx;
      match_cnt <= match_nx;
      miss_cnt  <= miss_nx;
      expected  <= expected_nx;
      err_count <= err_nx;
      err_pulse <= pulse_nx;
      locked    <= state_nx == LOCKED;
    end
  // next state: advance only on ce samples
  always_comb begin
    state_nx = state;
    if (ce)
      case (state)
        SEARCH:  state_nx = LOCKING;
        LOCKING: state_nx = lock_hit ? LOCKED : LOCKING;
        LOCKED:  state_nx = loss_hit ? SEARCH : LOCKED;
        default: state_nx = SEARCH;
      endcase
  end
  // datapath next values; expected free-runs once locked so one bad sample costs one error
  always_comb begin
    expected_nx = !ce ? expected : in_locked ? expected + 1'b1 : d + 1'b1;
    match_nx    = !ce ? match_cnt : (state == LOCKING && hit) ? match_cnt + 1'b1 : '0;
    miss_nx     = !ce ? miss_cnt : (in_locked && !hit) ? miss_cnt + 1'b1 : '0;
    pulse_nx    = ce && in_locked && !hit;
    err_nx      = (pulse_nx && ~&err_count) ? err_count + 1'b1 : err_count;
  end
`ifdef LATENCY_MEAS_EN
  // latency sampled on each locked ce sample, held otherwise
  always_ff @(posedge clk)
    if (!rst_n) latency <= '0;
    else if (ce && in_locked) latency <= ref_d - d;
`else
  logic unused_ref;
  assign unused_ref = ^ref_d;
  assign latency    = '0;
`endif
endmodule
